// File: rtl/if_fetch_stage_if.sv
// Bundle of the fetch stage's signals: next-PC selection inputs, the
// instruction-memory port, and the IF/ID pipeline register outputs.
// The fetch stage uses the master side; decode, the PC mux chain and
// instruction memory use the slave side.
interface if_fetch_stage_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      pc_next;
  logic             redirect;
  logic             stall;
  logic [31:0]      imem_rdata;
  logic [31:0]      pc;
  logic [31:0]      imem_addr;
  logic [31:0]      pc_plus4;
  logic [31:0]      ifid_instr;
  logic [31:0]      ifid_pc_plus4;
  logic             ifid_valid;
  logic             misalign;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    input  pc_next, redirect, stall, imem_rdata,
    output pc, imem_addr, pc_plus4, ifid_instr, ifid_pc_plus4,
           ifid_valid, misalign, fetch_count
  );

  modport slave (
    output pc_next, redirect, stall, imem_rdata,
    input  pc, imem_addr, pc_plus4, ifid_instr, ifid_pc_plus4,
           ifid_valid, misalign, fetch_count
  );
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC register and the IF/ID
// pipeline register. Redirect flushes IF/ID and wins over stall; stall
// freezes everything; otherwise the stage advances one instruction per edge.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  if_fetch_stage_if.master   bus
);

  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic [31:0]      ifid_instr;
  logic [31:0]      ifid_pc_plus4;
  logic             ifid_valid;
  logic             misalign;
  logic [CNT_W-1:0] fetch_count;
  logic [31:0]      pc_aligned;
  logic             pc_next_odd;

  // Sequential successor and the word-aligned form of the selected next PC;
  // the PC always loads with its low two bits forced to zero.
  assign pc_plus4    = pc + 32'd4;
  assign pc_aligned  = {bus.pc_next[31:2], 2'b00};
  assign pc_next_odd = (bus.pc_next[1:0] != 2'b00);

  // PC, IF/ID register, sticky misalign flag and fetch counter.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its neighbours, like real flip-flops.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous -- it takes effect only at a rising edge,
    // so asserting rst_n between edges leaves all outputs unchanged until then.
    if (!rst_n) begin
      pc            <= RESET_PC;
      ifid_instr    <= NOP_INSTR;
      ifid_pc_plus4 <= 32'd0;
      ifid_valid    <= 1'b0;
      misalign      <= 1'b0;
      fetch_count   <= '0;
    end else if (bus.redirect) begin
      // Control transfer resolved: jump to target, inject one bubble.
      pc            <= pc_aligned;
      ifid_instr    <= NOP_INSTR;
      ifid_pc_plus4 <= 32'd0;
      ifid_valid    <= 1'b0;
      if (pc_next_odd) misalign <= 1'b1;
    end else if (!bus.stall) begin
      // Normal advance: capture the instruction at pc and move on.
      pc            <= pc_aligned;
      ifid_instr    <= bus.imem_rdata;
      ifid_pc_plus4 <= pc_plus4;
      ifid_valid    <= 1'b1;
      fetch_count   <= fetch_count + 1'b1;
      if (pc_next_odd) misalign <= 1'b1;
    end
  end

  assign bus.pc            = pc;
  assign bus.imem_addr     = pc;
  assign bus.pc_plus4      = pc_plus4;
  assign bus.ifid_instr    = ifid_instr;
  assign bus.ifid_pc_plus4 = ifid_pc_plus4;
  assign bus.ifid_valid    = ifid_valid;
  assign bus.misalign      = misalign;
  assign bus.fetch_count   = fetch_count;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: reset, stall, redirect under stall,
// PC wrap, sticky misalign, counter wrap and mid-operation reset.
module tb_if_fetch_stage;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  if_fetch_stage_if #(.CNT_W(CNT_W)) bus ();

  if_fetch_stage #(
    .RESET_PC  (32'h0040_0000),
    .NOP_INSTR (32'h0000_0000),
    .CNT_W     (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] nxt, input logic [31:0] instr,
                       input logic redir, input logic stl);
    bus.pc_next    = nxt;
    bus.imem_rdata = instr;
    bus.redirect   = redir;
    bus.stall      = stl;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(32'h0000_0123, 32'hDEAD_BEEF, 1'b1, 1'b0);  // reset must override redirect
    tick();
    tick();
    checks++; if (bus.pc !== 32'h0040_0000) begin errors++; $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h0040_0000); end
    checks++; if (bus.imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL reset_imem_addr: got %h want %h", bus.imem_addr, 32'h0040_0000); end
    checks++; if (bus.pc_plus4 !== 32'h0040_0004) begin errors++; $display("FAIL reset_pc_plus4: got %h want %h", bus.pc_plus4, 32'h0040_0004); end
    checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.ifid_valid); end
    checks++; if (bus.ifid_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", bus.ifid_instr); end
    checks++; if (bus.ifid_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_ifid_pc4: got %h want 0", bus.ifid_pc_plus4); end
    checks++; if (bus.fetch_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.fetch_count); end
    checks++; if (bus.misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", bus.misalign); end
  endtask

  task automatic test_first_fetch();
    rst_n = 1'b1;
    drive(32'h0040_0004, 32'h2008_0005, 1'b0, 1'b0);
    tick();
    checks++; if (bus.ifid_instr !== 32'h2008_0005) begin errors++; $display("FAIL first_instr: got %h want %h", bus.ifid_instr, 32'h2008_0005); end
    checks++; if (bus.ifid_pc_plus4 !== 32'h0040_0004) begin errors++; $display("FAIL first_ifid_pc4: got %h want %h", bus.ifid_pc_plus4, 32'h0040_0004); end
    checks++; if (bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b want 1", bus.ifid_valid); end
    checks++; if (bus.pc !== 32'h0040_0004) begin errors++; $display("FAIL first_pc: got %h want %h", bus.pc, 32'h0040_0004); end
    checks++; if (bus.fetch_count !== 4'd1) begin errors++; $display("FAIL first_count: got %0d want 1", bus.fetch_count); end
  endtask

  task automatic test_stall();
    drive(32'h0040_0008, 32'h1111_1111, 1'b0, 1'b0);
    tick();  // pc = 0x00400008, count = 2
    for (int i = 0; i < 3; i++) begin
      // Misaligned pc_next on a stalled edge must not set misalign.
      drive(32'h0040_000E, 32'hA000_0000 + 32'(i), 1'b0, 1'b1);
      tick();
    end
    checks++; if (bus.pc !== 32'h0040_0008) begin errors++; $display("FAIL stall_pc: got %h want %h", bus.pc, 32'h0040_0008); end
    checks++; if (bus.ifid_instr !== 32'h1111_1111) begin errors++; $display("FAIL stall_instr: got %h want %h", bus.ifid_instr, 32'h1111_1111); end
    checks++; if (bus.ifid_pc_plus4 !== 32'h0040_0008) begin errors++; $display("FAIL stall_ifid_pc4: got %h want %h", bus.ifid_pc_plus4, 32'h0040_0008); end
    checks++; if (bus.fetch_count !== 4'd2) begin errors++; $display("FAIL stall_count: got %0d want 2", bus.fetch_count); end
    checks++; if (bus.misalign !== 1'b0) begin errors++; $display("FAIL stall_misalign: got %b want 0", bus.misalign); end
    drive(32'h0040_000C, 32'h2222_2222, 1'b0, 1'b0);
    tick();
    checks++; if (bus.pc !== 32'h0040_000C) begin errors++; $display("FAIL resume_pc: got %h want %h", bus.pc, 32'h0040_000C); end
    checks++; if (bus.ifid_instr !== 32'h2222_2222) begin errors++; $display("FAIL resume_instr: got %h want %h", bus.ifid_instr, 32'h2222_2222); end
    checks++; if (bus.ifid_pc_plus4 !== 32'h0040_000C) begin errors++; $display("FAIL resume_ifid_pc4: got %h want %h", bus.ifid_pc_plus4, 32'h0040_000C); end
    checks++; if (bus.fetch_count !== 4'd3) begin errors++; $display("FAIL resume_count: got %0d want 3", bus.fetch_count); end
  endtask

  task automatic test_redirect_under_stall();
    drive(32'h0040_0100, 32'h3333_3333, 1'b1, 1'b1);
    tick();
    checks++; if (bus.pc !== 32'h0040_0100) begin errors++; $display("FAIL redir_pc: got %h want %h", bus.pc, 32'h0040_0100); end
    checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b want 0", bus.ifid_valid); end
    checks++; if (bus.ifid_instr !== 32'h0) begin errors++; $display("FAIL redir_instr: got %h want 0", bus.ifid_instr); end
    checks++; if (bus.ifid_pc_plus4 !== 32'h0) begin errors++; $display("FAIL redir_ifid_pc4: got %h want 0", bus.ifid_pc_plus4); end
    checks++; if (bus.fetch_count !== 4'd3) begin errors++; $display("FAIL redir_count: got %0d want 3", bus.fetch_count); end
    drive(32'h0040_0104, 32'h2409_0007, 1'b0, 1'b0);
    tick();
    checks++; if (bus.ifid_instr !== 32'h2409_0007) begin errors++; $display("FAIL target_instr: got %h want %h", bus.ifid_instr, 32'h2409_0007); end
    checks++; if (bus.ifid_pc_plus4 !== 32'h0040_0104) begin errors++; $display("FAIL target_ifid_pc4: got %h want %h", bus.ifid_pc_plus4, 32'h0040_0104); end
    checks++; if (bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL target_valid: got %b want 1", bus.ifid_valid); end
    checks++; if (bus.fetch_count !== 4'd4) begin errors++; $display("FAIL target_count: got %0d want 4", bus.fetch_count); end
  endtask

  task automatic test_pc_wrap();
    drive(32'hFFFF_FFFC, 32'h5555_5555, 1'b1, 1'b0);
    tick();
    checks++; if (bus.pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: got %h want %h", bus.pc, 32'hFFFF_FFFC); end
    checks++; if (bus.pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc_plus4: got %h want 0", bus.pc_plus4); end
    drive(32'h0000_0000, 32'h4444_4444, 1'b0, 1'b0);
    tick();
    checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL wrap_adv_pc: got %h want 0", bus.pc); end
    checks++; if (bus.ifid_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_ifid_pc4: got %h want 0", bus.ifid_pc_plus4); end
    checks++; if (bus.ifid_instr !== 32'h4444_4444) begin errors++; $display("FAIL wrap_instr: got %h want %h", bus.ifid_instr, 32'h4444_4444); end
    checks++; if (bus.fetch_count !== 4'd5) begin errors++; $display("FAIL wrap_count: got %0d want 5", bus.fetch_count); end
  endtask

  task automatic test_misalign();
    logic [31:0] exp_pc;
    drive(32'h0040_0102, 32'h6666_6666, 1'b1, 1'b0);
    tick();
    checks++; if (bus.pc !== 32'h0040_0100) begin errors++; $display("FAIL mis_pc: got %h want %h", bus.pc, 32'h0040_0100); end
    checks++; if (bus.misalign !== 1'b1) begin errors++; $display("FAIL mis_set: got %b want 1", bus.misalign); end
    exp_pc = 32'h0040_0100;
    for (int i = 0; i < 10; i++) begin
      exp_pc = exp_pc + 32'd4;
      drive(exp_pc, 32'h7000_0000 + 32'(i), 1'b0, 1'b0);
      tick();
      checks++; if (bus.misalign !== 1'b1) begin errors++; $display("FAIL mis_sticky[%0d]: got %b want 1", i, bus.misalign); end
    end
    checks++; if (bus.pc !== 32'h0040_0128) begin errors++; $display("FAIL mis_adv_pc: got %h want %h", bus.pc, 32'h0040_0128); end
    checks++; if (bus.fetch_count !== 4'd15) begin errors++; $display("FAIL mis_count: got %0d want 15", bus.fetch_count); end
    rst_n = 1'b0;
    tick();
    checks++; if (bus.misalign !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b want 0", bus.misalign); end
    rst_n = 1'b1;
  endtask

  task automatic test_count_wrap_and_mid_reset();
    logic [31:0] exp_pc;
    exp_pc = 32'h0040_0000;
    for (int i = 0; i < 16; i++) begin
      exp_pc = exp_pc + 32'd4;
      drive(exp_pc, 32'h8000_0000 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    checks++; if (bus.fetch_count !== 4'd0) begin errors++; $display("FAIL cnt_wrap: got %0d want 0", bus.fetch_count); end
    checks++; if (bus.pc !== 32'h0040_0040) begin errors++; $display("FAIL cnt_wrap_pc: got %h want %h", bus.pc, 32'h0040_0040); end
    drive(32'h0040_0044, 32'h9999_9999, 1'b0, 1'b0);
    tick();  // count = 1, valid = 1, pc = 0x00400044
    rst_n = 1'b0;
    drive(32'h0040_0200, 32'hAAAA_AAAA, 1'b1, 1'b0);
    #3;  // between edges: nothing may change yet
    checks++; if (bus.pc !== 32'h0040_0044) begin errors++; $display("FAIL midrst_hold_pc: got %h want %h", bus.pc, 32'h0040_0044); end
    checks++; if (bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL midrst_hold_valid: got %b want 1", bus.ifid_valid); end
    checks++; if (bus.fetch_count !== 4'd1) begin errors++; $display("FAIL midrst_hold_count: got %0d want 1", bus.fetch_count); end
    tick();
    checks++; if (bus.pc !== 32'h0040_0000) begin errors++; $display("FAIL midrst_pc: got %h want %h", bus.pc, 32'h0040_0000); end
    checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", bus.ifid_valid); end
    checks++; if (bus.ifid_instr !== 32'h0) begin errors++; $display("FAIL midrst_instr: got %h want 0", bus.ifid_instr); end
    checks++; if (bus.ifid_pc_plus4 !== 32'h0) begin errors++; $display("FAIL midrst_ifid_pc4: got %h want 0", bus.ifid_pc_plus4); end
    checks++; if (bus.fetch_count !== 4'd0) begin errors++; $display("FAIL midrst_count: got %0d want 0", bus.fetch_count); end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect_under_stall();
    test_pc_wrap();
    test_misalign();
    test_count_wrap_and_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline.
- Owns the PC register and the IF/ID pipeline register.
- Presents pc to instruction memory and produces pc_plus4 for the next-PC selection chain (branch / jump / jr muxes).
- Consumes the chain's final selected address as pc_next; handles stall, redirect-flush, misalignment and a fetch counter.

Parameters:
- RESET_PC, 32'h00400000: PC value loaded on reset.
- NOP_INSTR, 32'h00000000: instruction word inserted into IF/ID on reset or flush.
- CNT_W, 32: width of fetch_count.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- pc_next  in  32  selected next PC from the PC mux chain (already includes the sequential pc_plus4 case).
- redirect  in  1  branch taken / jmp / jal / jr / jalr resolved this cycle; flush IF/ID.
- stall  in  1  hazard hold from decode; freeze PC and IF/ID.
- imem_rdata  in  32  instruction word at imem_addr, combinational same-cycle read.
- pc  out  32  current fetch PC (register).
- imem_addr  out  32  equals pc, combinational.
- pc_plus4  out  32  pc + 4, combinational, to the PC mux chain.
- ifid_instr  out  32  IF/ID instruction register.
- ifid_pc_plus4  out  32  IF/ID copy of pc_plus4.
- ifid_valid  out  1  IF/ID holds a real fetched instruction.
- misalign  out  1  sticky flag: a non-word-aligned pc_next was loaded.
- fetch_count  out  CNT_W  number of instructions captured into IF/ID.

Behaviour:
- Reset: one clock, synchronous, active-low; sampled only at rising edge of clk with rst_n low. Resulting values:
  - pc = RESET_PC
  - ifid_instr = NOP_INSTR
  - ifid_pc_plus4 = 0
  - ifid_valid = 0
  - misalign = 0
  - fetch_count = 0
- Reset overrides redirect and stall. Reset asserted mid-operation discards the in-flight IF/ID content; outputs change only at the edge.
- Combinational outputs: imem_addr = pc; pc_plus4 = pc + 32'd4, modulo 2^32 (0xFFFFFFFC -> 0x00000000).
- Per rising edge with rst_n = 1, in priority order:
  - redirect = 1 (wins over stall):
    - pc <= {pc_next[31:2], 2'b00}
    - ifid_instr <= NOP_INSTR; ifid_pc_plus4 <= 0; ifid_valid <= 0
    - fetch_count unchanged
  - else stall = 1: pc, ifid_*, fetch_count all hold.
  - else normal advance:
    - pc <= {pc_next[31:2], 2'b00}
    - ifid_instr <= imem_rdata; ifid_pc_plus4 <= pc_plus4; ifid_valid <= 1
    - fetch_count <= fetch_count + 1, wrapping at 2^CNT_W
- Latency:
  - Instruction at pc appears on ifid_instr exactly 1 edge after being presented, if not stalled or redirected.
  - A redirect produces exactly one bubble in IF/ID; the target instruction is captured on the following un-stalled edge.
- Misalignment:
  - On any edge where pc loads (redirect or advance), if pc_next[1:0] != 0 then misalign <= 1.
  - The PC is still loaded with low bits forced to 00.
  - misalign stays 1 until reset. No effect on a stalled edge.
- Simultaneous redirect + stall: redirect behaviour applies in full; the stall is ignored for that edge.
- No X-propagation allowed: all registers are explicitly reset.

Test Plan:
1. Reset/first fetch (RESET_PC=0x00400000): hold rst_n=0 for 2 edges -> pc=0x00400000, ifid_valid=0, ifid_instr=0, fetch_count=0. Release with pc_next=pc_plus4 and imem_rdata=0x20080005 -> after 1 edge: ifid_instr=0x20080005, ifid_pc_plus4=0x00400004, ifid_valid=1, pc=0x00400004, fetch_count=1.
2. Stall: at pc=0x00400008, stall=1 for 3 edges with imem_rdata changing -> pc, ifid_instr, ifid_pc_plus4 and fetch_count all unchanged. Drop stall -> advance resumes on the next edge.
3. Redirect under stall: redirect=1, stall=1, pc_next=0x00400100 -> pc=0x00400100, ifid_valid=0, ifid_instr=0, fetch_count unchanged. Next un-stalled edge captures the instruction at 0x00400100 with ifid_pc_plus4=0x00400104.
4. Wrap: force pc=0xFFFFFFFC via redirect -> pc_plus4=0x00000000. Advancing with pc_next=pc_plus4 -> pc=0x00000000, ifid_pc_plus4=0x00000000.
5. Misalign: redirect with pc_next=0x00400102 -> pc=0x00400100, misalign=1. misalign stays 1 over 10 normal edges and clears only after rst_n=0 at an edge.
6. Counter wrap and mid-operation reset (CNT_W=4):
   - 16 normal advances -> fetch_count=0.
   - rst_n pulled low between edges -> no output change until the next edge, then full reset values.
